phase_sweep_ctrl: RTL and testbench

//  Sequences the phase-detector bench through all four reference phases (0/45/90/135 deg).
//  Per phase: drives the reference-select code, holds off for a settle interval, averages 2^AVG_LOG2 ADPLL error samples, reports one signed mean.

---
 rtl/phase_sweep_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_phase_sweep_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_sweep_ctrl.sv
// phase_sweep_ctrl: steps the reference selector through phases 0..3, settles, then averages ADPLL error per phase.
// Define PHSWEEP_MINMAX_EN to also track per-phase min/max samples; otherwise result_min_o/result_max_o are tied to 0.
module phase_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 1024,
    parameter int AVG_LOG2      = 4,
    parameter int ERR_W         = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             continuous_i,
    input  logic [ERR_W-1:0] error_i,
    input  logic             error_valid_i,
    output logic [1:0]       ps_select_o,
    output logic             adpll_en_o,
    output logic             busy_o,
    output logic             result_valid_o,
    output logic [1:0]       result_phase_o,
    output logic [ERR_W-1:0] result_mean_o,
    output logic [ERR_W-1:0] result_min_o,
    output logic [ERR_W-1:0] result_max_o,
    output logic             done_o,
    output logic [2:0]       dbg_state_o
);
    localparam int ACC_W = ERR_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_ACCUM  = 3'd2,
        ST_REPORT = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic                    load_settle;
    logic                    take_sample;
    logic                    last_sample;
    logic [1:0]              phase_q;
    logic [SET_W-1:0]        settle_cnt_q;
    logic [CNT_W-1:0]        sample_cnt_q;
    logic signed [ERR_W-1:0] err_s;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_sum;
    logic [1:0]              res_phase_q;
    logic [ERR_W-1:0]        res_mean_q;

    // error_valid_i is a one-cycle strobe with no back-pressure: a sample is
    // consumed on any clk_i where it is high in ACCUM and silently dropped otherwise.
    assign err_s   = $signed(error_i);
    assign acc_sum = acc_q + ACC_W'(err_s);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        load_settle = 1'b0;
        take_sample = 1'b0;
        last_sample = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d     = ST_SETTLE;
                    load_settle = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == '0) begin
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (error_valid_i) begin
                    take_sample = 1'b1;
                    if (sample_cnt_q == LAST_SAMPLE) begin
                        last_sample = 1'b1;
                        state_d     = ST_REPORT;
                    end
                end
            end
            ST_REPORT: begin
                if (phase_q == 2'd3) begin
                    state_d = ST_DONE;
                end else begin
                    state_d     = ST_SETTLE;
                    load_settle = 1'b1;
                end
            end
            ST_DONE: begin
                if (continuous_i) begin
                    state_d     = ST_SETTLE;
                    load_settle = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Results are captured on the edge that accepts the last sample so they
    // are already stable during the single REPORT cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            phase_q      <= '0;
            settle_cnt_q <= '0;
            sample_cnt_q <= '0;
            acc_q        <= '0;
            res_phase_q  <= '0;
            res_mean_q   <= '0;
        end else begin
            if (load_settle) begin
                settle_cnt_q <= SETTLE_LOAD;
            end else if (state_q == ST_SETTLE && settle_cnt_q != '0) begin
                settle_cnt_q <= settle_cnt_q - 1'b1;
            end

            if (state_q == ST_IDLE && start_i) begin
                phase_q <= 2'd0;
            end else if (state_q == ST_REPORT && phase_q != 2'd3) begin
                phase_q <= phase_q + 2'd1;
            end else if (state_q == ST_DONE && continuous_i) begin
                phase_q <= 2'd0;
            end

            if (take_sample) begin
                if (last_sample) begin
                    acc_q        <= '0;
                    sample_cnt_q <= '0;
                    res_mean_q   <= ERR_W'(acc_sum >>> AVG_LOG2);
                    res_phase_q  <= phase_q;
                end else begin
                    acc_q        <= acc_sum;
                    sample_cnt_q <= sample_cnt_q + 1'b1;
                end
            end
        end
    end

`ifdef PHSWEEP_MINMAX_EN
    logic signed [ERR_W-1:0] min_q;
    logic signed [ERR_W-1:0] max_q;
    logic signed [ERR_W-1:0] min_d;
    logic signed [ERR_W-1:0] max_d;
    logic [ERR_W-1:0]        res_min_q;
    logic [ERR_W-1:0]        res_max_q;

    // The first sample of a phase seeds both extremes.
    always_comb begin
        min_d = err_s;
        max_d = err_s;
        if (sample_cnt_q != '0) begin
            if (min_q < err_s) begin
                min_d = min_q;
            end
            if (max_q > err_s) begin
                max_d = max_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            min_q     <= '0;
            max_q     <= '0;
            res_min_q <= '0;
            res_max_q <= '0;
        end else if (take_sample) begin
            min_q <= min_d;
            max_q <= max_d;
            if (last_sample) begin
                res_min_q <= min_d;
                res_max_q <= max_d;
            end
        end
    end

    assign result_min_o = res_min_q;
    assign result_max_o = res_max_q;
`else
    assign result_min_o = '0;
    assign result_max_o = '0;
`endif

    // The ADPLL is kept running through every state, including IDLE.
    assign adpll_en_o     = 1'b1;
    assign ps_select_o    = phase_q;
    assign busy_o         = (state_q != ST_IDLE);
    assign result_valid_o = (state_q == ST_REPORT);
    assign done_o         = (state_q == ST_DONE);
    assign result_phase_o = res_phase_q;
    assign result_mean_o  = res_mean_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_phase_sweep_ctrl.sv
// Bench for phase_sweep_ctrl: pre-built random/directed stimulus is played back, outputs are
// logged per cycle and compared against a sweep-level model walked over the same stimulus.
module tb_phase_sweep_ctrl;
    localparam int S    = 8;
    localparam int L2   = 2;
    localparam int N    = 4;
    localparam int W    = 8;
    localparam int MAXC = 4096;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         cont;
    logic [W-1:0] err;
    logic         err_valid;
    logic [1:0]   ps_select;
    logic         adpll_en;
    logic         busy;
    logic         result_valid;
    logic [1:0]   result_phase;
    logic [W-1:0] result_mean;
    logic [W-1:0] result_min;
    logic [W-1:0] result_max;
    logic         done;
    logic [2:0]   dbg_state;

    always #5 clk = ~clk;

    phase_sweep_ctrl #(
        .SETTLE_CYCLES(S),
        .AVG_LOG2     (L2),
        .ERR_W        (W)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .start_i       (start),
        .continuous_i  (cont),
        .error_i       (err),
        .error_valid_i (err_valid),
        .ps_select_o   (ps_select),
        .adpll_en_o    (adpll_en),
        .busy_o        (busy),
        .result_valid_o(result_valid),
        .result_phase_o(result_phase),
        .result_mean_o (result_mean),
        .result_min_o  (result_min),
        .result_max_o  (result_max),
        .done_o        (done),
        .dbg_state_o   (dbg_state)
    );

    // stimulus schedule, one entry per clock cycle
    bit         st_rst[MAXC];
    bit         st_start[MAXC];
    bit         st_cont[MAXC];
    bit         st_valid[MAXC];
    logic [7:0] st_data[MAXC];
    int         ncyc = 0;

    // observed and expected outputs per cycle
    int obs_busy[MAXC], obs_ps[MAXC], obs_rv[MAXC], obs_done[MAXC], obs_en[MAXC];
    int obs_phase[MAXC], obs_mean[MAXC], obs_min[MAXC], obs_max[MAXC];
    int exp_busy[MAXC], exp_ps[MAXC], exp_rv[MAXC], exp_done[MAXC];
    int exp_phase[MAXC], exp_mean[MAXC], exp_min[MAXC], exp_max[MAXC];

    int m_ps, m_phase, m_mean, m_min, m_max;
    int n_tests = 0;
    int n_fail  = 0;

    int dir_vals[16] = '{10, 12, 14, 16, -1, -2, -1, -2,
                         -128, -128, -128, -128, 127, -128, 5, -3};

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit rbit();
        return bit'($urandom_range(0, 1));
    endfunction

    function automatic logic [7:0] rand8();
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic gen(input bit r, input bit s, input bit c, input bit v, input logic [7:0] d);
        if (ncyc < MAXC) begin
            st_rst[ncyc]   = r;
            st_start[ncyc] = s;
            st_cont[ncyc]  = c;
            st_valid[ncyc] = v;
            st_data[ncyc]  = d;
            ncyc++;
        end
    endtask

    task automatic gen_idle(input int n);
        for (int i = 0; i < n; i++) gen(1'b0, 1'b0, rbit(), rbit(), rand8());
    endtask

    // Shapes stimulus for one sweep after its start/decision cycle; the model
    // below decides independently which samples really count.
    task automatic gen_sweep(input int vals[16], input int gap_max, input bit start_lvl,
                             input bit cont_done, input int rst_phase, input bit settle_valid);
        for (int p = 0; p < 4; p++) begin
            for (int s = 0; s < S; s++)
                gen(1'b0, start_lvl, rbit(), settle_valid | rbit(), rand8());
            for (int i = 0; i < N; i++) begin
                if (p == rst_phase && i == 2) begin
                    gen(1'b1, start_lvl, rbit(), 1'b1, rand8());
                    return;
                end
                repeat ($urandom_range(0, gap_max)) gen(1'b0, start_lvl, rbit(), 1'b0, rand8());
                gen(1'b0, start_lvl, rbit(), 1'b1, 8'(vals[p*N+i]));
            end
            gen(1'b0, start_lvl, rbit(), rbit(), rand8());
        end
        gen(1'b0, start_lvl, cont_done, rbit(), rand8());
    endtask

    task automatic random_vals(output int vals[16]);
        foreach (vals[i]) vals[i] = int'($urandom_range(0, 255)) - 128;
    endtask

    task automatic put(input int t, input int b, input int rv, input int d);
        if (t < MAXC) begin
            exp_busy[t]  = b;
            exp_rv[t]    = rv;
            exp_done[t]  = d;
            exp_ps[t]    = m_ps;
            exp_phase[t] = m_phase;
            exp_mean[t]  = m_mean;
`ifdef PHSWEEP_MINMAX_EN
            exp_min[t]   = m_min;
            exp_max[t]   = m_max;
`else
            exp_min[t]   = 0;
            exp_max[t]   = 0;
`endif
        end
    endtask

    task automatic clear_model();
        m_ps = 0; m_phase = 0; m_mean = 0; m_min = 0; m_max = 0;
    endtask

    // Sweep-level reference: after a start decision at cycle k a phase settles on
    // cycles k+1..k+S, then the next N valid samples count, then one report cycle.
    task automatic model_walk();
        int t, n, sum, smin, smax, v;
        bit stop, again;
        clear_model();
        t = 0;
        while (t < ncyc) begin
            put(t, 0, 0, 0);
            if (st_rst[t]) begin
                clear_model();
                t++;
            end else if (!st_start[t]) begin
                t++;
            end else begin
                t++;
                stop  = (t >= ncyc);
                again = 1'b1;
                while (again && !stop) begin
                    again = 1'b0;
                    for (int p = 0; p < 4 && !stop; p++) begin
                        m_ps = p;
                        for (int s = 0; s < S && !stop; s++) begin
                            put(t, 1, 0, 0);
                            stop = st_rst[t];
                            t++;
                            if (t >= ncyc) stop = 1'b1;
                        end
                        n = 0; sum = 0; smin = 0; smax = 0;
                        while (n < N && !stop) begin
                            put(t, 1, 0, 0);
                            if (st_rst[t]) begin
                                stop = 1'b1;
                            end else if (st_valid[t]) begin
                                v = int'($signed(st_data[t]));
                                if (n == 0 || v < smin) smin = v;
                                if (n == 0 || v > smax) smax = v;
                                sum += v;
                                n++;
                            end
                            t++;
                            if (t >= ncyc) stop = 1'b1;
                        end
                        if (!stop) begin
                            m_phase = p;
                            m_mean  = (sum - (((sum % N) + N) % N)) / N;
                            m_min   = smin;
                            m_max   = smax;
                            put(t, 1, 1, 0);
                            stop = st_rst[t];
                            t++;
                            if (t >= ncyc) stop = 1'b1;
                        end
                    end
                    if (!stop) begin
                        put(t, 1, 0, 1);
                        stop  = st_rst[t];
                        again = !stop && st_cont[t];
                        t++;
                        if (t >= ncyc) stop = 1'b1;
                    end
                end
                if (stop) clear_model();
            end
        end
    endtask

    initial begin
        int rv[16];
        bit c;
        reset = 1'b1; start = 1'b0; cont = 1'b0; err = '0; err_valid = 1'b0;

        // reset, then a directed sweep with a strobe every cycle
        repeat (4) gen(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        gen_idle(3);
        gen(1'b0, 1'b1, rbit(), rbit(), rand8());
        gen_sweep(dir_vals, 0, 1'b0, 1'b0, -1, 1'b1);
        gen_idle(3);

        // continuous mode: second sweep chains without start, then drops out
        gen(1'b0, 1'b1, rbit(), rbit(), rand8());
        random_vals(rv);
        gen_sweep(rv, 3, 1'b0, 1'b1, -1, 1'b0);
        random_vals(rv);
        gen_sweep(rv, 2, 1'b0, 1'b0, -1, 1'b0);
        gen_idle(4);

        // reset in the middle of phase 2 accumulation, then a fresh sweep
        gen(1'b0, 1'b1, rbit(), rbit(), rand8());
        random_vals(rv);
        gen_sweep(rv, 2, 1'b0, 1'b0, 2, 1'b0);
        gen_idle(3);
        gen(1'b0, 1'b1, rbit(), rbit(), rand8());
        random_vals(rv);
        gen_sweep(rv, 1, 1'b0, 1'b0, -1, 1'b0);
        gen_idle(2);

        // start held high through a whole sweep, still high in the IDLE cycle after DONE
        gen(1'b0, 1'b1, rbit(), rbit(), rand8());
        random_vals(rv);
        gen_sweep(rv, 1, 1'b1, 1'b0, -1, 1'b0);
        gen(1'b0, 1'b1, rbit(), rbit(), rand8());
        random_vals(rv);
        gen_sweep(rv, 2, 1'b0, 1'b0, -1, 1'b0);

        // random sweeps with random continuous decisions
        for (int k = 0; k < 4; k++) begin
            gen_idle($urandom_range(1, 5));
            gen(1'b0, 1'b1, rbit(), rbit(), rand8());
            c = rbit();
            random_vals(rv);
            gen_sweep(rv, 3, 1'b0, c, -1, 1'b0);
            if (c) begin
                random_vals(rv);
                gen_sweep(rv, 3, 1'b0, 1'b0, -1, 1'b0);
            end
        end
        gen_idle(6);

        model_walk();

        for (int cy = 0; cy < ncyc; cy++) begin
            @(posedge clk);
            #1;
            reset     = st_rst[cy];
            start     = st_start[cy];
            cont      = st_cont[cy];
            err_valid = st_valid[cy];
            err       = st_data[cy];
            @(negedge clk);
            obs_busy[cy]  = int'(busy);
            obs_ps[cy]    = int'(ps_select);
            obs_rv[cy]    = int'(result_valid);
            obs_done[cy]  = int'(done);
            obs_en[cy]    = int'(adpll_en);
            obs_phase[cy] = int'(result_phase);
            obs_mean[cy]  = int'($signed(result_mean));
            obs_min[cy]   = int'($signed(result_min));
            obs_max[cy]   = int'($signed(result_max));
        end

        for (int cy = 1; cy < ncyc; cy++) begin
            check_eq($sformatf("busy@%0d", cy), obs_busy[cy], exp_busy[cy]);
            check_eq($sformatf("ps_select@%0d", cy), obs_ps[cy], exp_ps[cy]);
            check_eq($sformatf("result_valid@%0d", cy), obs_rv[cy], exp_rv[cy]);
            check_eq($sformatf("done@%0d", cy), obs_done[cy], exp_done[cy]);
            check_eq($sformatf("adpll_en@%0d", cy), obs_en[cy], 1);
            check_eq($sformatf("result_phase@%0d", cy), obs_phase[cy], exp_phase[cy]);
            check_eq($sformatf("result_mean@%0d", cy), obs_mean[cy], exp_mean[cy]);
            check_eq($sformatf("result_min@%0d", cy), obs_min[cy], exp_min[cy]);
            check_eq($sformatf("result_max@%0d", cy), obs_max[cy], exp_max[cy]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
